// File: rtl/lsu_ctrl.sv
// Load/store unit between the memory stage and a word-only data memory.
// Handles byte/halfword loads with extension and sub-word stores via read-modify-write.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [XLEN-1:0]   mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, RMW_WR, ST_WR, RESP} state_t;

  // The load/store direction is carried by which path the FSM takes.
  state_t              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                accept;
  logic                req_err;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [XLEN-1:0]     ld_ext;
  logic [XLEN-1:0]     merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 > 3'd5))
      req_err = 1'b1;
    else if (req_funct3[1:0] == 2'd1 && req_addr[0])
      req_err = 1'b1;
    else if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  always_comb begin
    ld_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_read_data;
    endcase
  end

  // Per-lane merge: a halfword store puts wdata[15:8] into the odd lane of its pair.
  generate
    for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
      logic       lane_sel;
      logic [7:0] st_byte;
      assign lane_sel = funct3_q[0] ? (addr_q[1] == 1'(gi / 2))
                                    : (addr_q[1:0] == 2'(gi));
      assign st_byte  = (funct3_q[0] && (gi % 2 == 1)) ? wdata_q[15:8] : wdata_q[7:0];
      assign merged[8*gi +: 8] = lane_sel ? st_byte : mem_read_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          rdata_d  = '0;
          if (req_err)
            state_d = RESP;
          else if (!req_we)
            state_d = LOAD;
          else if (req_funct3[1:0] == 2'd2) begin
            state_d     = ST_WR;
            mem_wdata_d = req_wdata;
          end else
            state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        mem_wdata_d = merged;
        state_d     = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      ST_WR:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready      = (state_q == IDLE) && !rst;
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_read       = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write      = (state_q == RMW_WR) || (state_q == ST_WR);
  assign mem_addr       = (state_q == IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: byte-addressed reference model, directed plus random requests.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] env_mem [0:255] = '{default: '0};
  logic [7:0]  ref_mem [0:1023] = '{default: '0};

  lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT: synchronous write, gated combinational read.
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr[9:2]] <= mem_write_data;
  end
  assign mem_read_data = mem_read ? env_mem[mem_addr[9:2]] : 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    return (int'(a[1:0]) % ref_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a[9:2]) * 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = ref_size(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < ref_size(f3); i++) ref_mem[int'(a[9:0]) + i] = 8'(wd >> (8 * i));
  endtask

  task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got_rdata,
                          output logic [31:0] got_wdata);
    logic        e;
    logic        done;
    logic [31:0] exp_rdata, exp_wdata, aligned;
    int          lat, nwr, nrd, exp_lat, exp_wr, exp_rd;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    e = ref_err(we, f3, addr);
    aligned = {addr[31:2], 2'b00};
    exp_rdata = '0; exp_wdata = '0;
    if (e) begin
      exp_lat = 1; exp_wr = 0; exp_rd = 0;
    end else if (!we) begin
      exp_lat = 2; exp_wr = 0; exp_rd = 1;
      exp_rdata = ref_load(f3, addr);
    end else begin
      ref_store(f3, addr, wd);
      exp_wdata = ref_word(addr);
      exp_wr = 1;
      exp_rd = (ref_size(f3) < 4) ? 1 : 0;
      exp_lat = (ref_size(f3) < 4) ? 3 : 2;
    end
    @(posedge clk);
    lat = 0; nwr = 0; nrd = 0; done = 1'b0; got_rdata = '0; got_wdata = '0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_read) begin
        nrd++;
        check("rd_addr", mem_addr, aligned);
      end
      if (mem_write) begin
        nwr++;
        got_wdata = mem_write_data;
        check("wr_addr", mem_addr, aligned);
        check("wr_data", mem_write_data, exp_wdata);
      end
      if (resp_valid) begin
        done = 1'b1;
        got_rdata = resp_rdata;
        check("latency", lat, exp_lat);
        check("resp_err", {31'd0, resp_err}, {31'd0, e});
        check("resp_rdata", resp_rdata, exp_rdata);
      end
      // Garbage requests while busy must be ignored.
      req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end
    if (!done) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    check("wr_count", nwr, exp_wr);
    check("rd_count", nrd, exp_rd);
    $display("txn we=%0d f3=%0d addr=%h wdata=%h err=%0d rdata=%h wr=%h lat=%0d",
             we, f3, addr, wd, e, got_rdata, got_wdata, lat);
  endtask

  initial begin
    logic [31:0] r, w;
    logic        rw;
    logic [2:0]  rf;
    logic [31:0] ra;

    // Power-on reset
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_outputs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_outputs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("post_rst_maddr", mem_addr, 32'd0);

    // Word store / load
    transact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, r, w);
    check("sw_wdata", w, 32'hDEADBEEF);
    transact(1'b0, 3'd2, 32'h10, 32'h0, r, w);
    check("lw_rdata", r, 32'hDEADBEEF);

    // Byte store by read-modify-write, then signed/unsigned byte loads
    transact(1'b1, 3'd2, 32'h10, 32'h11223344, r, w);
    transact(1'b1, 3'd0, 32'h12, 32'h123456AB, r, w);
    check("sb_merge", w, 32'h11AB3344);
    transact(1'b0, 3'd0, 32'h12, 32'h0, r, w);
    check("lb_rdata", r, 32'hFFFFFFAB);
    transact(1'b0, 3'd4, 32'h12, 32'h0, r, w);
    check("lbu_rdata", r, 32'h000000AB);

    // Halfword store and loads
    transact(1'b1, 3'd2, 32'h14, 32'h0, r, w);
    transact(1'b1, 3'd1, 32'h16, 32'hCAFE8001, r, w);
    check("sh_merge", w, 32'h80010000);
    transact(1'b0, 3'd1, 32'h16, 32'h0, r, w);
    check("lh_rdata", r, 32'hFFFF8001);
    transact(1'b0, 3'd5, 32'h16, 32'h0, r, w);
    check("lhu_rdata", r, 32'h00008001);

    // Error cases: misaligned and illegal funct3
    transact(1'b0, 3'd2, 32'h13, 32'h0, r, w);
    transact(1'b1, 3'd1, 32'h11, 32'hFFFF, r, w);
    transact(1'b0, 3'd3, 32'h10, 32'h0, r, w);
    transact(1'b1, 3'd4, 32'h10, 32'h55, r, w);
    transact(1'b0, 3'd7, 32'h10, 32'h0, r, w);

    // Reset in the middle of a read-modify-write: the store must not land
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_rmw_rd", {31'd0, mem_read}, 32'd1);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    check("abort_outputs", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
    check("abort_maddr", mem_addr, 32'd0);
    check("abort_mwdata", mem_write_data, 32'd0);
    @(negedge clk);
    check("abort_no_write", {31'd0, mem_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    check("abort_mem", env_mem[8], ref_word(32'h20));

    // Back-to-back requests with req_valid held high throughout
    transact(1'b1, 3'd0, 32'h30, 32'h77, r, w);
    transact(1'b1, 3'd1, 32'h32, 32'hBEEF, r, w);
    transact(1'b0, 3'd2, 32'h30, 32'h0, r, w);
    transact(1'b0, 3'd4, 32'h33, 32'h0, r, w);

    // Random traffic, including addresses beyond the 1 KiB window
    for (int k = 0; k < 80; k++) begin
      rw = 1'($urandom);
      rf = 3'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) ra[1:0] = 2'b00;
      transact(rw, rf, ra, $urandom, r, w);
    end

    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) check("mem_word", env_mem[i], ref_word(32'(i * 4)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
